// File: rtl/sprite_compositor_pkg.sv
// Shared types and helpers for the sprite compositor: RGB332 pixel type,
// transparent colour, report FSM states and the collision pair bit mapping.
package sprite_compositor_pkg;

  typedef logic [7:0] rgb332_t;

  localparam rgb332_t TRANSPARENT = 8'h00;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REPORT = 1'b1
  } report_state_t;

  // Bit position of layer pair (i,j), i<j, in lexicographic order over n layers:
  // (0,1),(0,2),...,(0,n-1),(1,2),... Rows before i hold sum_{r<i}(n-1-r) pairs.
  function automatic int pair_index(input int i, input int j, input int n);
    return (i * (2 * n - i - 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel stream in/out plus the collision report handshake of the compositor.
// The compositor is the slave; the video source / report consumer is the master.
interface sprite_compositor_if #(
  parameter int NUM_LAYERS = 4
) ();

  logic                                      de;
  logic                                      frame_end;
  logic [NUM_LAYERS*8-1:0]                   layer_pix;
  logic [7:0]                                pix_out;
  logic                                      de_out;
  logic                                      coll_valid;
  logic                                      coll_ack;
  logic [NUM_LAYERS*(NUM_LAYERS-1)/2-1:0]    coll_map;
  logic                                      coll_overrun;

  modport master (
    output de, frame_end, layer_pix, coll_ack,
    input  pix_out, de_out, coll_valid, coll_map, coll_overrun
  );

  modport slave (
    input  de, frame_end, layer_pix, coll_ack,
    output pix_out, de_out, coll_valid, coll_map, coll_overrun
  );

endinterface

// File: rtl/sprite_compositor_collision_accum.sv
// Pair-wise sprite collision detection, per-frame accumulation and the
// report handshake. Inputs are the stage-1 registered pixel attributes.
module collision_accum
  import sprite_compositor_pkg::*;
#(
  parameter int NUM_LAYERS = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   de,
  input  logic                                   frame_end,
  input  logic [NUM_LAYERS-1:0]                  opaque,
  input  logic                                   coll_ack,
  output logic                                   coll_valid,
  output logic [NUM_LAYERS*(NUM_LAYERS-1)/2-1:0] coll_map,
  output logic                                   coll_overrun
);

  localparam int NUM_PAIRS = NUM_LAYERS * (NUM_LAYERS - 1) / 2;

  logic [NUM_PAIRS-1:0] pair_hit;
  logic [NUM_PAIRS-1:0] snapshot;
  logic [NUM_PAIRS-1:0] accum_reg;
  logic [NUM_PAIRS-1:0] coll_map_reg;
  logic                 coll_valid_reg;
  logic                 coll_overrun_reg;
  report_state_t        state_reg;

  // One AND gate per layer pair; blanked pixels never count as a collision.
  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_row
    for (genvar gj = gi + 1; gj < NUM_LAYERS; gj++) begin : g_col
      localparam int BIT = pair_index(gi, gj, NUM_LAYERS);
      assign pair_hit[BIT] = de & opaque[gi] & opaque[gj];
    end
  end

  // The last pixel of the frame is included in its own report.
  assign snapshot = accum_reg | pair_hit;

  // Accumulator plus report FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      accum_reg        <= '0;
      coll_map_reg     <= '0;
      coll_valid_reg   <= 1'b0;
      coll_overrun_reg <= 1'b0;
    end else begin
      accum_reg <= frame_end ? '0 : snapshot;
      case (state_reg)
        ST_IDLE: begin
          if (frame_end) begin
            coll_map_reg     <= snapshot;
            coll_valid_reg   <= 1'b1;
            coll_overrun_reg <= 1'b0;
            state_reg        <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (frame_end) begin
            if (coll_ack) begin
              // Old report consumed this cycle: the new one stands alone.
              coll_map_reg     <= snapshot;
              coll_overrun_reg <= 1'b0;
            end else begin
              // Consumer is behind: merge so no collision is lost.
              coll_map_reg     <= coll_map_reg | snapshot;
              coll_overrun_reg <= 1'b1;
            end
          end else if (coll_ack) begin
            coll_valid_reg   <= 1'b0;
            coll_overrun_reg <= 1'b0;
            state_reg        <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign coll_valid   = coll_valid_reg;
  assign coll_map     = coll_map_reg;
  assign coll_overrun = coll_overrun_reg;

endmodule

// File: rtl/sprite_compositor.sv
// Sprite layer compositor: two-stage priority merge of NUM_LAYERS RGB332
// layers (layer 0 on top) with per-frame pair-wise collision reporting.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int         NUM_LAYERS = 4,
  parameter logic [7:0] BG_COLOR   = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  sprite_compositor_if.slave   bus
);

  localparam int NUM_PAIRS = NUM_LAYERS * (NUM_LAYERS - 1) / 2;

  logic [NUM_LAYERS-1:0]   opaque_in;
  logic [NUM_LAYERS*8-1:0] layer_s1_reg;
  logic [NUM_LAYERS-1:0]   opaque_s1_reg;
  logic                    de_s1_reg;
  logic                    frame_end_s1_reg;
  rgb332_t                 pix_next;
  rgb332_t                 pix_out_reg;
  logic                    de_out_reg;
  logic                    coll_valid;
  logic [NUM_PAIRS-1:0]    coll_map;
  logic                    coll_overrun;

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_opaque
    assign opaque_in[gi] = (bus.layer_pix[8*gi +: 8] != TRANSPARENT);
  end

  // Stage 1: capture the raw pixel slice and its opacity mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_s1_reg     <= '0;
      opaque_s1_reg    <= '0;
      de_s1_reg        <= 1'b0;
      frame_end_s1_reg <= 1'b0;
    end else begin
      layer_s1_reg     <= bus.layer_pix;
      opaque_s1_reg    <= opaque_in;
      de_s1_reg        <= bus.de;
      frame_end_s1_reg <= bus.frame_end;
    end
  end

  // Priority mux: scan from the bottom layer up so the lowest opaque index wins.
  always_comb begin
    pix_next = BG_COLOR;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (opaque_s1_reg[k]) pix_next = layer_s1_reg[8*k +: 8];
    end
    if (!de_s1_reg) pix_next = 8'h00;
  end

  // Stage 2: registered composited pixel and aligned display enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_out_reg <= '0;
      de_out_reg  <= 1'b0;
    end else begin
      pix_out_reg <= pix_next;
      de_out_reg  <= de_s1_reg;
    end
  end

  collision_accum #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_accum (
    .clk          (clk),
    .rst          (rst),
    .de           (de_s1_reg),
    .frame_end    (frame_end_s1_reg),
    .opaque       (opaque_s1_reg),
    .coll_ack     (bus.coll_ack),
    .coll_valid   (coll_valid),
    .coll_map     (coll_map),
    .coll_overrun (coll_overrun)
  );

  assign bus.pix_out      = pix_out_reg;
  assign bus.de_out       = de_out_reg;
  assign bus.coll_valid   = coll_valid;
  assign bus.coll_map     = coll_map;
  assign bus.coll_overrun = coll_overrun;

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised and directed bench for sprite_compositor (4 layers, BG 0x25)
// against a frame-level behavioural model of compositing and collision reports.
module tb_sprite_compositor;

  localparam int         N  = 4;
  localparam logic [7:0] BG = 8'h25;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sprite_compositor_if #(.NUM_LAYERS(N)) bus ();

  sprite_compositor #(
    .NUM_LAYERS (N),
    .BG_COLOR   (BG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: what the outputs must show after the current clock edge.
  logic [31:0] prev_lp;
  logic        prev_de;
  logic        prev_fe;
  logic [5:0]  m_acc;
  logic [5:0]  m_map;
  logic        m_valid;
  logic        m_over;
  logic [7:0]  m_pix;
  logic        m_de;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Colliding layer pairs of one pixel, enumerated (0,1),(0,2),..,(2,3).
  function automatic logic [5:0] pairs_of(input logic [31:0] lp);
    logic [5:0] r;
    int b;
    r = '0;
    b = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (lp[8*i +: 8] != 8'h00 && lp[8*j +: 8] != 8'h00) r[b] = 1'b1;
        b++;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] composite(input logic d, input logic [31:0] lp);
    if (!d) return 8'h00;
    for (int k = 0; k < N; k++) begin
      if (lp[8*k +: 8] != 8'h00) return lp[8*k +: 8];
    end
    return BG;
  endfunction

  task automatic model_reset();
    prev_lp = '0; prev_de = 1'b0; prev_fe = 1'b0;
    m_acc = '0; m_map = '0; m_valid = 1'b0; m_over = 1'b0;
    m_pix = '0; m_de = 1'b0;
  endtask

  // Pixel entered one cycle ago reaches the outputs now; its frame_end meets
  // the ack presented in this cycle.
  task automatic model_update(input logic ack, input logic d, input logic f, input logic [31:0] lp);
    logic [5:0] hits;
    logic [5:0] snap;
    hits  = prev_de ? pairs_of(prev_lp) : 6'd0;
    m_pix = composite(prev_de, prev_lp);
    m_de  = prev_de;
    if (prev_fe) begin
      snap  = m_acc | hits;
      m_acc = '0;
      if (!m_valid || ack) begin
        m_map  = snap;
        m_over = 1'b0;
      end else begin
        m_map  = m_map | snap;
        m_over = 1'b1;
      end
      m_valid = 1'b1;
    end else begin
      m_acc = m_acc | hits;
      if (m_valid && ack) begin
        m_valid = 1'b0;
        m_over  = 1'b0;
      end
    end
    prev_lp = lp; prev_de = d; prev_fe = f;
  endtask

  task automatic compare_all();
    check("pix_out",      {24'd0, bus.pix_out},  {24'd0, m_pix});
    check("de_out",       {31'd0, bus.de_out},   {31'd0, m_de});
    check("coll_valid",   {31'd0, bus.coll_valid},   {31'd0, m_valid});
    check("coll_map",     {26'd0, bus.coll_map},     {26'd0, m_map});
    check("coll_overrun", {31'd0, bus.coll_overrun}, {31'd0, m_over});
  endtask

  // One pixel per call; called at posedge+1 and returns at the next posedge+1.
  task automatic step(input logic d, input logic f, input logic [31:0] lp, input logic ack);
    bus.de = d; bus.frame_end = f; bus.layer_pix = lp; bus.coll_ack = ack;
    @(posedge clk);
    model_update(ack, d, f, lp);
    #1;
    compare_all();
    $display("px de=%0b fe=%0b lp=%08h ack=%0b -> pix=%02h de_out=%0b valid=%0b map=%06b ovr=%0b",
             d, f, lp, ack, bus.pix_out, bus.de_out, bus.coll_valid, bus.coll_map, bus.coll_overrun);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_coll_valid", {31'd0, bus.coll_valid}, 32'd0);
    #1;
    rst = 1'b0;
    $display("reset pulse at %0t", $time);
  endtask

  initial begin
    bus.de = 1'b0; bus.frame_end = 1'b0; bus.layer_pix = '0; bus.coll_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pix_out",  {24'd0, bus.pix_out}, 32'd0);
    check("reset_de_out",   {31'd0, bus.de_out}, 32'd0);
    check("reset_coll_map", {26'd0, bus.coll_map}, 32'd0);
    check("reset_overrun",  {31'd0, bus.coll_overrun}, 32'd0);
    rst = 1'b0;

    // Layer 1 wins over transparent layer 0.
    step(1'b1, 1'b0, 32'h031C_E000, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("prio_pix", {24'd0, bus.pix_out}, 32'h0000_00E0);
    check("prio_de",  {31'd0, bus.de_out}, 32'd1);

    // Background when active and nothing opaque; black when blanked.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    check("bg_pix", {24'd0, bus.pix_out}, 32'h0000_0025);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("blank_pix", {24'd0, bus.pix_out}, 32'd0);
    check("blank_de",  {31'd0, bus.de_out}, 32'd0);

    // Pair 02 visible, pair 13 only while blanked.
    pulse_reset();
    step(1'b1, 1'b0, 32'h001C_00E0, 1'b0);
    step(1'b0, 1'b0, 32'h0300_E000, 1'b0);
    step(1'b1, 1'b1, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("frame_valid", {31'd0, bus.coll_valid}, 32'd1);
    check("frame_map",   {26'd0, bus.coll_map}, 32'b000010);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("frame_ack_valid", {31'd0, bus.coll_valid}, 32'd0);

    // Unacked frame A (01) merged with frame B (23).
    step(1'b1, 1'b0, 32'h0000_2211, 1'b0);
    step(1'b1, 1'b1, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h4433_0000, 1'b0);
    step(1'b1, 1'b1, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("merge_map",     {26'd0, bus.coll_map}, 32'b100001);
    check("merge_overrun", {31'd0, bus.coll_overrun}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("merge_ack_valid",   {31'd0, bus.coll_valid}, 32'd0);
    check("merge_ack_overrun", {31'd0, bus.coll_overrun}, 32'd0);

    // Ack coincident with the next snapshot replaces instead of merging.
    step(1'b1, 1'b0, 32'h0000_2211, 1'b0);
    step(1'b1, 1'b1, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0033_2200, 1'b0);
    step(1'b1, 1'b1, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("replace_map",     {26'd0, bus.coll_map}, 32'b001000);
    check("replace_valid",   {31'd0, bus.coll_valid}, 32'd1);
    check("replace_overrun", {31'd0, bus.coll_overrun}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset mid-frame drops the earlier pair 01 hit.
    step(1'b1, 1'b0, 32'h0000_2211, 1'b0);
    pulse_reset();
    step(1'b1, 1'b0, 32'h4400_2200, 1'b0);
    step(1'b1, 1'b1, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_frame_map", {26'd0, bus.coll_map}, 32'b010000);

    // Randomised frames, acks and occasional resets.
    for (int c = 0; c < 600; c++) begin
      logic [31:0] lp;
      for (int k = 0; k < N; k++) begin
        lp[8*k +: 8] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      end
      if ($urandom_range(0, 249) == 0) pulse_reset();
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0), lp,
           ($urandom_range(0, 9) < 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
